// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared state type, nibble width and index-width helper
package nibble_serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam int NIBBLE_W = 4;
  function automatic int idx_w(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction
endpackage

// File: rtl/nibble_serial_adder_add.sv
// nibble_add: combinational 4-bit ripple-carry adder
module nibble_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] w_c;
  assign w_c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end
  assign co = w_c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that feeds one nibble per clock through a single 4-bit adder
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_w(NIB);
  state_t           r_state, w_next;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a, r_b, r_work, w_work;
  logic             r_carry, w_co, w_last, w_accept;
  logic [3:0]       w_s;
  nibble_add u_add (
    .x (r_a[NIBBLE_W*r_idx +: NIBBLE_W]),
    .y (r_b[NIBBLE_W*r_idx +: NIBBLE_W]),
    .ci(r_carry),
    .s (w_s),
    .co(w_co)
  );
  assign w_last   = (r_state == ADD) && (r_idx == IW'(NIB - 1));
  assign w_accept = start && (r_state != ADD);
  always_comb begin
    w_work = r_work;
    w_work[NIBBLE_W*r_idx +: NIBBLE_W] = w_s;
    w_next = (r_state == ADD) ? (w_last ? DONE : ADD) : (start ? ADD : IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_work  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_idx   <= '0;
      end
      if (r_state == ADD) begin
        r_work  <= w_work;
        r_carry <= w_co;
        r_idx   <= r_idx + IW'(1);
      end
      if (w_last) begin
        sum  <= w_work;
        cout <= w_co;
        ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_work[WIDTH-1] != r_a[WIDTH-1]);
      end
    end
  end
  // status flags come straight from the state register, so no input reaches them combinationally
  assign busy = (r_state == ADD);
  assign done = (r_state == DONE);
endmodule
